// File: rtl/muldiv_sequencer_if.sv
// Handshake and operand bundle between the EX stage and the RV32M multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, rs1_i, rs2_i, flush_i,
    input  stall_o, busy_o, valid_o, result_o
  );

  modport slave (
    input  start_i, op_i, rs1_i, rs2_i, flush_i,
    output stall_o, busy_o, valid_o, result_o
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M sequencer: radix-2 shift-add multiply and restoring divide,
// with a fast path for divide-by-zero and signed overflow.
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic                clk,
  input  logic                resetn,
  muldiv_sequencer_if.slave   bus
);
  localparam int unsigned CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   rs1_q, rs1_d, rs2_q, rs2_d;
  logic [CW-1:0]     count_q, count_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic              neg1_q, neg1_d, neg2_q, neg2_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              busy_q, busy_d;

  logic              sgn1, sgn2, n1, n2;
  logic [XLEN-1:0]   abs1, abs2;
  logic [XLEN:0]     mul_sum, mul_upper;
  logic [XLEN:0]     div_top;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic              div_zero, div_ovf;

  assign sgn1 = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM);
  assign sgn2 = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
  assign n1   = sgn1 & rs1_q[XLEN-1];
  assign n2   = sgn2 & rs2_q[XLEN-1];
  assign abs1 = n1 ? -rs1_q : rs1_q;
  assign abs2 = n2 ? -rs2_q : rs2_q;

  // Multiply keeps {partial product, multiplier}; the carry of the add is shifted in.
  assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, acc_q};
  assign mul_upper = prod_q[0] ? mul_sum : {1'b0, prod_q[2*XLEN-1:XLEN]};

  // Divide keeps {remainder, quotient}; the shifted remainder needs one extra bit.
  assign div_top  = prod_q[2*XLEN-1:XLEN-1];
  assign div_ge   = div_top >= {1'b0, acc_q};
  assign div_diff = div_top[XLEN-1:0] - acc_q;

  assign mul_fix  = (neg1_q ^ neg2_q) ? -prod_q : prod_q;
  assign quo_fix  = (neg1_q ^ neg2_q) ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
  assign rem_fix  = neg1_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];

  assign div_zero = op_q[2] && (rs2_q == '0);
  assign div_ovf  = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
                    (rs1_q == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_q == '1);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    count_d  = count_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    result_d = result_q;
    busy_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          op_d    = bus.op_i;
          rs1_d   = bus.rs1_i;
          rs2_d   = bus.rs2_i;
          state_d = S_PREP;
          busy_d  = 1'b1;
        end
      end
      S_PREP: begin
        neg1_d  = n1;
        neg2_d  = n2;
        count_d = CW'(XLEN - 1);
        if (op_q[2]) begin
          acc_d  = abs2;
          prod_d = {{XLEN{1'b0}}, abs1};
        end else begin
          acc_d  = abs1;
          prod_d = {{XLEN{1'b0}}, abs2};
        end
        if (div_zero) begin
          result_d = op_q[1] ? rs1_q : '1;
          state_d  = S_DONE;
        end else if (div_ovf) begin
          result_d = op_q[1] ? '0 : rs1_q;
          state_d  = S_DONE;
        end else begin
          state_d = S_CALC;
          busy_d  = 1'b1;
        end
      end
      S_CALC: begin
        busy_d = 1'b1;
        if (op_q[2]) begin
          prod_d = {(div_ge ? div_diff : div_top[XLEN-1:0]), prod_q[XLEN-2:0], div_ge};
        end else begin
          prod_d = {mul_upper, prod_q[XLEN-1:1]};
        end
        if (count_q == '0) begin
          state_d = S_FIX;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      S_FIX: begin
        if (op_q[2]) begin
          result_d = op_q[1] ? rem_fix : quo_fix;
        end else if (op_q == OP_MUL) begin
          result_d = mul_fix[XLEN-1:0];
        end else begin
          result_d = mul_fix[2*XLEN-1:XLEN];
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flush overrides everything: back to IDLE, nothing accepted, result untouched.
    if (bus.flush_i) begin
      state_d  = S_IDLE;
      op_d     = op_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      result_d = result_q;
      busy_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      result_q <= result_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.stall_o  = (bus.start_i && (state_q == S_IDLE)) || busy_q;
  assign bus.busy_o   = busy_q;
  assign bus.valid_o  = (state_q == S_DONE) && !bus.flush_i;
  assign bus.result_o = result_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M cases, random ops
// against an arithmetic reference, back-to-back, flush and mid-operation reset.
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  muldiv_sequencer_if #(.XLEN(32)) bus ();

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint     sa = longint'($signed(a));
    longint     sb = longint'($signed(b));
    longint     ua = longint'({32'd0, a});
    longint     ub = longint'({32'd0, b});
    int         ia = int'(a);
    int         ib = int'(b);
    logic       ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    logic [63:0] p;
    logic [31:0] r;
    case (op)
      3'd0: begin p = 64'(ua * ub); r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 2;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 35;
  endfunction

  // Issues one operation starting at the next falling edge; returns at the valid_o cycle
  // with start_i still high so another operation may follow immediately.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_res = ref_result(op, a, b);
    int          lat = ref_latency(op, a, b);
    int          cyc = 0;
    logic        got = 1'b0;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.rs1_i   = a;
    bus.rs2_i   = b;
    while (!got && cyc < 60) begin
      #1;
      if (bus.valid_o === 1'b1) begin
        got = 1'b1;
      end else begin
        checks++;
        if (bus.stall_o !== 1'b1) begin
          failures++;
          $display("FAIL %s stall cyc=%0d got=%b exp=1", name, cyc, bus.stall_o);
        end
        checks++;
        if (bus.busy_o !== (cyc != 0)) begin
          failures++;
          $display("FAIL %s busy cyc=%0d got=%b exp=%b", name, cyc, bus.busy_o, cyc != 0);
        end
        @(negedge clk);
        cyc++;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s timeout no valid_o within 60 cycles", name);
    end else begin
      if (cyc != lat) begin
        failures++;
        $display("FAIL %s latency got=%0d exp=%0d", name, cyc, lat);
      end
      checks++;
      if (bus.result_o !== exp_res) begin
        failures++;
        $display("FAIL %s result got=%h exp=%h (op=%0d a=%h b=%h)", name, bus.result_o, exp_res, op, a, b);
      end
      checks++;
      if (bus.stall_o !== 1'b0 || bus.busy_o !== 1'b0) begin
        failures++;
        $display("FAIL %s done_stall got stall=%b busy=%b exp 0 0", name, bus.stall_o, bus.busy_o);
      end
    end
  endtask

  task automatic go_idle(input string name);
    @(negedge clk);
    bus.start_i = 1'b0;
    #1;
    checks++;
    if (bus.stall_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0) begin
      failures++;
      $display("FAIL %s idle got stall=%b busy=%b valid=%b exp 0 0 0", name, bus.stall_o, bus.busy_o, bus.valid_o);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.stall_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.result_o !== 32'd0) begin
      failures++;
      $display("FAIL reset got stall=%b busy=%b valid=%b result=%h exp 0 0 0 0",
               bus.stall_o, bus.busy_o, bus.valid_o, bus.result_o);
    end
    @(negedge clk);
    resetn = 1'b1;
    go_idle("reset_release");
  endtask

  task automatic test_directed();
    run_op("mul_7_m3",     3'd0, 32'd7,          32'hFFFF_FFFD); go_idle("mul_7_m3");
    run_op("mulh_min",     3'd1, 32'h8000_0000,  32'h8000_0000); go_idle("mulh_min");
    run_op("mulhu_max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF); go_idle("mulhu_max");
    run_op("mulhsu_m1_2",  3'd2, 32'hFFFF_FFFF,  32'd2);         go_idle("mulhsu_m1_2");
    run_op("div_m7_2",     3'd4, 32'hFFFF_FFF9,  32'd2);         go_idle("div_m7_2");
    run_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9,  32'd2);         go_idle("rem_m7_2");
    run_op("divu_100_7",   3'd5, 32'd100,        32'd7);         go_idle("divu_100_7");
    run_op("remu_100_7",   3'd7, 32'd100,        32'd7);         go_idle("remu_100_7");
    run_op("divu_by_zero", 3'd5, 32'd5,          32'd0);         go_idle("divu_by_zero");
    run_op("rem_by_zero",  3'd6, 32'd5,          32'd0);         go_idle("rem_by_zero");
    run_op("div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF); go_idle("div_ovf");
    run_op("rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF); go_idle("rem_ovf");
    run_op("divu_big",     3'd5, 32'hFFFF_FFFF,  32'hFFFF_FFFE); go_idle("divu_big");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op = 3'($urandom_range(0, 7));
      logic [31:0] a  = $urandom;
      logic [31:0] b  = $urandom;
      int unsigned sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = b >> $urandom_range(1, 31);
      run_op("random", op, a, b);
      if ($urandom_range(0, 1) == 1) go_idle("random");
    end
    go_idle("random_end");
  endtask

  task automatic test_back_to_back();
    run_op("b2b_mul",   3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    run_op("b2b_divu",  3'd5, 32'hDEAD_BEEF, 32'd13);
    run_op("b2b_rem0",  3'd6, 32'hCAFE_F00D, 32'd0);
    run_op("b2b_mulh",  3'd1, 32'hFFFF_FF00, 32'h0000_0100);
    go_idle("b2b_end");
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    @(negedge clk);
    prev = bus.result_o;
    bus.start_i = 1'b1;
    bus.op_i    = 3'd4;
    bus.rs1_i   = 32'd1000;
    bus.rs2_i   = 32'd3;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (bus.valid_o !== 1'b0) begin
        failures++;
        $display("FAIL flush early_valid cyc=%0d got=%b exp=0", c, bus.valid_o);
      end
      @(negedge clk);
    end
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    bus.start_i = 1'b0;
    #1;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.stall_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.result_o !== prev) begin
      failures++;
      $display("FAIL flush cyc11 got busy=%b stall=%b valid=%b result=%h exp 0 0 0 %h",
               bus.busy_o, bus.stall_o, bus.valid_o, bus.result_o, prev);
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.valid_o !== 1'b0 || bus.result_o !== prev) begin
        failures++;
        $display("FAIL flush after got valid=%b result=%h exp 0 %h", bus.valid_o, bus.result_o, prev);
      end
    end
    run_op("flush_then_mul", 3'd0, 32'd3, 32'd4);
    go_idle("flush_then_mul");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = 3'd0;
    bus.rs1_i   = 32'h0001_2345;
    bus.rs2_i   = 32'h0000_0055;
    repeat (20) @(negedge clk);
    bus.start_i = 1'b0;
    resetn      = 1'b0;
    #1;
    checks++;
    if (bus.stall_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.result_o !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid got stall=%b busy=%b valid=%b result=%h exp 0 0 0 0",
               bus.stall_o, bus.busy_o, bus.valid_o, bus.result_o);
    end
    @(negedge clk);
    resetn = 1'b1;
    run_op("reset_then_mulhu", 3'd3, 32'd2, 32'd3);
    go_idle("reset_then_mulhu");
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.op_i    = 3'd0;
    bus.rs1_i   = 32'd0;
    bus.rs2_i   = 32'd0;
    bus.flush_i = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative sequencer for the RV32M multiply/divide datapath in the execute stage of the kianv five-stage pipeline. It takes a decoded M-extension operation and its operands from EX and runs a radix-2 shift-add multiply or restoring divide over multiple cycles. It stalls the pipeline with a handshake until the result is ready, and resolves divide-by-zero and signed-overflow in a short fast path.

## Interface
Parameters:
- XLEN, 32, operand and result width. Only 32 is required; the counter width is $clog2(XLEN).

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- resetn  in  1  asynchronous, active-low reset
- start_i  in  1  EX holds a valid M-extension instruction; held high, operands stable, until valid_o
- op_i  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_i  in  XLEN  dividend / multiplicand
- rs2_i  in  XLEN  divisor / multiplier
- flush_i  in  1  pipeline flush of EX; aborts the current operation
- stall_o  out  1  freeze IF/ID/EX (combinational)
- busy_o  out  1  state is neither IDLE nor DONE (registered)
- valid_o  out  1  one-cycle pulse; result_o valid
- result_o  out  XLEN  result; holds its last value until the next DONE

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE:
  - start_i && !flush_i: latch op, rs1 and rs2 -> PREP.
  - Otherwise stay in IDLE.
- PREP:
  - Capture operand signs per op: MULH both signed; MULHSU rs1 signed only; MULHU/DIVU/REMU unsigned; MUL uses low bits, so signedness is irrelevant.
  - Load absolute values into the accumulator and the 2·XLEN product or remainder register; set count = XLEN-1.
  - Divide-by-zero (rs2 == 0, ops 4–7): quotient = all ones, remainder = rs1 unmodified; go directly to DONE.
  - Signed overflow (op 4/6, rs1 == 0x80000000, rs2 == 0xFFFFFFFF): DIV -> 0x80000000, REM -> 0; go directly to DONE.
  - Otherwise -> CALC.
- CALC: one iteration per cycle.
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the upper half; then shift the {upper, lower} pair right 1.
  - Divide: shift the remainder:quotient pair left 1; trial-subtract the divisor; on non-negative, keep the difference and set quotient LSB = 1.
  - When count == 0 -> FIX; otherwise decrement count.
- FIX:
  - Negate the product if the operand signs differ (signed operands only).
  - Negate the quotient if the dividend and divisor signs differ.
  - Negate the remainder if the dividend is negative.
  - Select the result: MUL low word; MULH/MULHSU/MULHU high word; DIV/DIVU quotient; REM/REMU remainder. Register it into result_o -> DONE.
- DONE: valid_o = 1; start_i is ignored; -> IDLE unconditionally. The pipeline advances on this cycle, so the same instruction is never restarted.
- stall_o = (start_i && state == IDLE) || busy_o. It is deasserted in DONE.
- flush_i high in any state: next state IDLE, valid_o not asserted, result_o unchanged. In IDLE, flush_i also blocks start acceptance.
- Reset: state IDLE, count 0, busy_o 0, valid_o 0, result_o 0, all datapath registers 0. Reset mid-operation discards the operation with no valid_o.

## Timing
- Cycle 0 = first cycle start_i is high in IDLE.
- Normal path: PREP at cycle 1, CALC cycles 2–33 (XLEN iterations), FIX at cycle 34, DONE/valid_o at cycle 35.
- Fast path (div-by-zero, overflow): DONE/valid_o at cycle 2.
- stall_o is high on cycles 0–34 (normal) or 0–1 (fast) and low on the DONE cycle.
- Back-to-back operations: the next start_i is accepted on the cycle after DONE at the earliest.
- Flush takes effect at the next edge; stall_o drops in the following cycle unless start_i is high again in IDLE.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB, valid_o at cycle 35, stall_o high on cycles 0–34.
- MULH rs1=rs2=0x80000000 -> 0x40000000. MULHU rs1=rs2=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0. Each has valid_o at cycle 2.
- Flush at cycle 10 of a DIV -> no valid_o, state IDLE at cycle 11, result_o unchanged. A following MUL 3×4 completes with 12.
- resetn dropped at cycle 20 of a MUL -> all outputs 0 immediately. After release, a MULHU 2×3 -> 0 with normal latency.
